// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Merges EX and MEM register-file write requests into one write port through
//   a small circular FIFO, and answers ID-stage forwarding queries against
//   every write that has not yet reached the register file.
//
// Ports
//   clk, rest                      clock, synchronous active-high reset
//   ex_wb_en_i / ex_rd_*_i         EX write request (addr, data)
//   mem_wb_en_i / mem_rd_*_i       MEM write request (load return), older than EX
//   wb_en_o / wb_rd_*_o            registered register-file write port
//   id_rs1_addr_i, id_rs2_addr_i   forwarding queries
//   fwd_rsN_hit_o / fwd_rsN_data_o youngest pending value for each query
//   stall_o                        fewer than two free FIFO slots
//   overflow_o                     sticky: some request was dropped
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int QDEPTH = 4,
    parameter int AW     = 5,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          rest,
    input  logic          ex_wb_en_i,
    input  logic [AW-1:0] ex_rd_addr_i,
    input  logic [DW-1:0] ex_rd_data_i,
    input  logic          mem_wb_en_i,
    input  logic [AW-1:0] mem_rd_addr_i,
    input  logic [DW-1:0] mem_rd_data_i,
    output logic          wb_en_o,
    output logic [AW-1:0] wb_rd_addr_o,
    output logic [DW-1:0] wb_rd_data_o,
    input  logic [AW-1:0] id_rs1_addr_i,
    input  logic [AW-1:0] id_rs2_addr_i,
    output logic          fwd_rs1_hit_o,
    output logic [DW-1:0] fwd_rs1_data_o,
    output logic          fwd_rs2_hit_o,
    output logic [DW-1:0] fwd_rs2_data_o,
    output logic          stall_o,
    output logic          overflow_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // FIFO storage and bookkeeping
    logic [AW-1:0] r_q_addr [QDEPTH];
    logic [DW-1:0] r_q_data [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Output register
    logic          r_wb_en;
    logic [AW-1:0] r_wb_addr;
    logic [DW-1:0] r_wb_data;
    logic          r_ovf;

    logic          w_mem_v;
    logic          w_ex_v;
    logic          w_nonempty;
    logic [CW:0]   w_free;
    logic          w_acc_mem;
    logic          w_acc_ex;
    logic          w_drop;
    logic          w_pop;
    logic [CW-1:0] w_push_n;
    logic [PW-1:0] w_ex_slot;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;

    logic [1:0][AW-1:0] w_rs;
    logic [1:0]         w_hit;
    logic [1:0][DW-1:0] w_fdata;

    // x0 writes are architecturally void: filter them before anything else.
    assign w_mem_v    = mem_wb_en_i && (mem_rd_addr_i != '0);
    assign w_ex_v     = ex_wb_en_i  && (ex_rd_addr_i  != '0);
    assign w_nonempty = (r_count != '0);

    // Slots available this cycle, counting the slot freed by the pop. When the
    // FIFO is empty the pop only happens if something is pushed, but then the
    // FIFO has QDEPTH free slots anyway, so the pop credit is not needed.
    assign w_free = (CW+1)'(QDEPTH) - {1'b0, r_count} + (CW+1)'(w_nonempty);

    // MEM is older, so it claims a slot first; EX is the first to be dropped.
    assign w_acc_mem = w_mem_v && (w_free != '0);
    assign w_acc_ex  = w_ex_v  && (w_free > (w_acc_mem ? (CW+1)'(1) : (CW+1)'(0)));
    assign w_drop    = (w_mem_v && !w_acc_mem) || (w_ex_v && !w_acc_ex);

    assign w_pop     = w_nonempty || w_acc_mem || w_acc_ex;
    assign w_push_n  = CW'(w_acc_mem) + CW'(w_acc_ex);
    assign w_ex_slot = r_wr_ptr + PW'(w_acc_mem);

    // Bypass: an empty FIFO hands the oldest incoming request straight to the
    // output register (it is still written into storage but consumed at once).
    always_comb begin
        w_head_addr = ex_rd_addr_i;
        w_head_data = ex_rd_data_i;
        if (w_nonempty) begin
            w_head_addr = r_q_addr[r_rd_ptr];
            w_head_data = r_q_data[r_rd_ptr];
        end else if (w_acc_mem) begin
            w_head_addr = mem_rd_addr_i;
            w_head_data = mem_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            if (w_acc_mem) begin
                r_q_addr[r_wr_ptr] <= mem_rd_addr_i;
                r_q_data[r_wr_ptr] <= mem_rd_data_i;
            end
            if (w_acc_ex) begin
                r_q_addr[w_ex_slot] <= ex_rd_addr_i;
                r_q_data[w_ex_slot] <= ex_rd_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + w_push_n - CW'(w_pop);
            r_wb_en  <= w_pop;
            if (w_pop) begin
                r_wb_addr <= w_head_addr;
                r_wb_data <= w_head_data;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Forwarding: scan from oldest to youngest so the last match wins.
    // Age order is output register, FIFO head..tail, incoming MEM, incoming EX.
    assign w_rs = {id_rs2_addr_i, id_rs1_addr_i};

    always_comb begin
        w_hit   = '0;
        w_fdata = '0;
        for (int p = 0; p < 2; p++) begin
            if (!rest && (w_rs[p] != '0)) begin
                if (r_wb_en && (r_wb_addr == w_rs[p])) begin
                    w_hit[p]   = 1'b1;
                    w_fdata[p] = r_wb_data;
                end
                for (int i = 0; i < QDEPTH; i++) begin
                    if ((CW'(i) < r_count) &&
                        (r_q_addr[r_rd_ptr + PW'(i)] == w_rs[p])) begin
                        w_hit[p]   = 1'b1;
                        w_fdata[p] = r_q_data[r_rd_ptr + PW'(i)];
                    end
                end
                if (mem_wb_en_i && (mem_rd_addr_i == w_rs[p])) begin
                    w_hit[p]   = 1'b1;
                    w_fdata[p] = mem_rd_data_i;
                end
                if (ex_wb_en_i && (ex_rd_addr_i == w_rs[p])) begin
                    w_hit[p]   = 1'b1;
                    w_fdata[p] = ex_rd_data_i;
                end
            end
        end
    end

    assign fwd_rs1_hit_o  = w_hit[0];
    assign fwd_rs1_data_o = w_fdata[0];
    assign fwd_rs2_hit_o  = w_hit[1];
    assign fwd_rs2_data_o = w_fdata[1];

    assign stall_o    = !rest && (r_count > CW'(QDEPTH - 2));
    assign wb_en_o      = r_wb_en;
    assign wb_rd_addr_o = r_wb_addr;
    assign wb_rd_data_o = r_wb_data;
    assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int QD = 4;

    logic        clk;
    logic        rest;
    logic        ex_wb_en_i;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        mem_wb_en_i;
    logic [4:0]  mem_rd_addr_i;
    logic [31:0] mem_rd_data_i;
    logic        wb_en_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        fwd_rs1_hit_o;
    logic [31:0] fwd_rs1_data_o;
    logic        fwd_rs2_hit_o;
    logic [31:0] fwd_rs2_data_o;
    logic        stall_o;
    logic        overflow_o;

    int n_chk  = 0;
    int n_pass = 0;

    wb_arbiter #(.QDEPTH(QD), .AW(5), .DW(32)) dut (
        .clk            (clk),
        .rest           (rest),
        .ex_wb_en_i     (ex_wb_en_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_rd_data_i   (ex_rd_data_i),
        .mem_wb_en_i    (mem_wb_en_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_rd_data_i  (mem_rd_data_i),
        .wb_en_o        (wb_en_o),
        .wb_rd_addr_o   (wb_rd_addr_o),
        .wb_rd_data_o   (wb_rd_data_o),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .fwd_rs1_hit_o  (fwd_rs1_hit_o),
        .fwd_rs1_data_o (fwd_rs1_data_o),
        .fwd_rs2_hit_o  (fwd_rs2_hit_o),
        .fwd_rs2_data_o (fwd_rs2_data_o),
        .stall_o        (stall_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a list of pending writes in age order plus the write port.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_en   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_ovf  = 1'b0;

    // One clock of the model using the inputs currently driven. Requests are
    // appended oldest first; a request is kept only if the list, after this
    // cycle's single write-back, still fits in QD entries.
    task automatic model_step();
        ent_t e;
        if (rest) begin
            mq.delete();
            m_en = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
        end else begin
            if (mem_wb_en_i && mem_rd_addr_i != 0) begin
                if (mq.size() <= QD) mq.push_back({mem_rd_addr_i, mem_rd_data_i});
                else m_ovf = 1'b1;
            end
            if (ex_wb_en_i && ex_rd_addr_i != 0) begin
                if (mq.size() <= QD) mq.push_back({ex_rd_addr_i, ex_rd_data_i});
                else m_ovf = 1'b1;
            end
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_en = 1'b1; m_addr = e.a; m_data = e.d;
            end else begin
                m_en = 1'b0;
            end
        end
    endtask

    // Youngest pending value for rs: {hit, data}.
    function automatic logic [32:0] model_fwd(input logic [4:0] rs);
        logic [32:0] r;
        r = '0;
        if (!rest && rs != 0) begin
            if (m_en && m_addr == rs) r = {1'b1, m_data};
            foreach (mq[i]) if (mq[i].a == rs) r = {1'b1, mq[i].d};
            if (mem_wb_en_i && mem_rd_addr_i == rs) r = {1'b1, mem_rd_data_i};
            if (ex_wb_en_i && ex_rd_addr_i == rs) r = {1'b1, ex_rd_data_i};
        end
        return r;
    endfunction

    task automatic drv(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic ev, input logic [4:0] ea, input logic [31:0] ed);
        mem_wb_en_i = mv; mem_rd_addr_i = ma; mem_rd_data_i = md;
        ex_wb_en_i  = ev; ex_rd_addr_i  = ea; ex_rd_data_i  = ed;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rest = 1'b1; idle(); id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        tick();
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
        id_rs1_addr_i = 5;
        #1;
        n_chk++; if (fwd_rs1_hit_o !== 1'b0) $display("FAIL reset_hit: got %b want 0", fwd_rs1_hit_o); else n_pass++;
        n_chk++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else n_pass++;
        n_chk++; if (wb_rd_addr_o !== 5'd0) $display("FAIL reset_addr: got %h want 0", wb_rd_addr_o); else n_pass++;
        n_chk++; if (wb_rd_data_o !== 32'd0) $display("FAIL reset_data: got %h want 0", wb_rd_data_o); else n_pass++;
        n_chk++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_o); else n_pass++;
        tick();
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL reset_ignore_req: got %b want 0", wb_en_o); else n_pass++;
        rest = 1'b0; idle(); id_rs1_addr_i = 0;
    endtask

    task automatic test_single();
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
        tick();
        n_chk++; if (wb_en_o !== 1'b1) $display("FAIL single_en: got %b want 1", wb_en_o); else n_pass++;
        n_chk++; if (wb_rd_addr_o !== 5'd5) $display("FAIL single_addr: got %h want 5", wb_rd_addr_o); else n_pass++;
        n_chk++; if (wb_rd_data_o !== 32'h11) $display("FAIL single_data: got %h want 11", wb_rd_data_o); else n_pass++;
        idle();
        tick();
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL single_en_off: got %b want 0", wb_en_o); else n_pass++;
        n_chk++; if (wb_rd_addr_o !== 5'd5 || wb_rd_data_o !== 32'h11)
            $display("FAIL single_hold: got %h/%h want 5/11", wb_rd_addr_o, wb_rd_data_o); else n_pass++;
    endtask

    task automatic test_simul();
        drv(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
        tick();
        n_chk++; if (wb_en_o !== 1'b1 || wb_rd_addr_o !== 5'd3 || wb_rd_data_o !== 32'hAA)
            $display("FAIL simul_first: got %b %h/%h want 1 3/aa", wb_en_o, wb_rd_addr_o, wb_rd_data_o); else n_pass++;
        idle();
        tick();
        n_chk++; if (wb_en_o !== 1'b1 || wb_rd_addr_o !== 5'd4 || wb_rd_data_o !== 32'hBB)
            $display("FAIL simul_second: got %b %h/%h want 1 4/bb", wb_en_o, wb_rd_addr_o, wb_rd_data_o); else n_pass++;
        tick();
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL simul_done: got %b want 0", wb_en_o); else n_pass++;
    endtask

    task automatic test_forward();
        drv(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        tick();
        drv(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        tick();
        // output register holds 2/0x200, FIFO holds 7/0x1 then 7/0x2
        idle(); id_rs1_addr_i = 7; id_rs2_addr_i = 0;
        #1;
        n_chk++; if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h2)
            $display("FAIL fwd_fifo_youngest: got %b/%h want 1/2", fwd_rs1_hit_o, fwd_rs1_data_o); else n_pass++;
        n_chk++; if (fwd_rs2_hit_o !== 1'b0 || fwd_rs2_data_o !== 32'h0)
            $display("FAIL fwd_x0: got %b/%h want 0/0", fwd_rs2_hit_o, fwd_rs2_data_o); else n_pass++;
        n_chk++; if (stall_o !== 1'b0) $display("FAIL fwd_stall: got %b want 0", stall_o); else n_pass++;
        drv(1'b1, 5'd7, 32'h4, 1'b1, 5'd7, 32'h3); id_rs2_addr_i = 2;
        #1;
        n_chk++; if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h3)
            $display("FAIL fwd_incoming_ex: got %b/%h want 1/3", fwd_rs1_hit_o, fwd_rs1_data_o); else n_pass++;
        n_chk++; if (fwd_rs2_hit_o !== 1'b1 || fwd_rs2_data_o !== 32'h200)
            $display("FAIL fwd_outreg: got %b/%h want 1/200", fwd_rs2_hit_o, fwd_rs2_data_o); else n_pass++;
        drv(1'b1, 5'd7, 32'h4, 1'b0, 5'd0, 32'h0);
        #1;
        n_chk++; if (fwd_rs1_hit_o !== 1'b1 || fwd_rs1_data_o !== 32'h4)
            $display("FAIL fwd_incoming_mem: got %b/%h want 1/4", fwd_rs1_hit_o, fwd_rs1_data_o); else n_pass++;
        idle(); id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        tick();
        n_chk++; if (wb_rd_addr_o !== 5'd7 || wb_rd_data_o !== 32'h1)
            $display("FAIL fwd_drain1: got %h/%h want 7/1", wb_rd_addr_o, wb_rd_data_o); else n_pass++;
        tick();
        n_chk++; if (wb_rd_addr_o !== 5'd7 || wb_rd_data_o !== 32'h2)
            $display("FAIL fwd_drain2: got %h/%h want 7/2", wb_rd_addr_o, wb_rd_data_o); else n_pass++;
        tick();
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL fwd_drained: got %b want 0", wb_en_o); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [4:0] got[$];
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 5'(2*i+1), 32'((2*i+1)*16), 1'b1, 5'(2*i+2), 32'((2*i+2)*16));
            #1;
            n_chk++; if (stall_o !== (i >= 3)) $display("FAIL ovf_stall_%0d: got %b want %b", i, stall_o, (i >= 3)); else n_pass++;
            tick();
            if (wb_en_o === 1'b1) got.push_back(wb_rd_addr_o);
            n_chk++; if (overflow_o !== (i == 4)) $display("FAIL ovf_flag_%0d: got %b want %b", i, overflow_o, (i == 4)); else n_pass++;
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wb_en_o === 1'b1) got.push_back(wb_rd_addr_o);
        end
        n_chk++; if (got.size() != 9) $display("FAIL ovf_count: got %0d writes want 9", got.size()); else n_pass++;
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            n_chk++; if (got[i] !== 5'(i+1)) $display("FAIL ovf_order_%0d: got %0d want %0d", i, got[i], i+1); else n_pass++;
        end
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_o); else n_pass++;
    endtask

    task automatic test_x0();
        rest = 1'b1; idle(); tick(); rest = 1'b0;
        n_chk++; if (overflow_o !== 1'b0) $display("FAIL x0_ovf_cleared: got %b want 0", overflow_o); else n_pass++;
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF); id_rs1_addr_i = 0;
        #1;
        n_chk++; if (fwd_rs1_hit_o !== 1'b0) $display("FAIL x0_hit: got %b want 0", fwd_rs1_hit_o); else n_pass++;
        tick();
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL x0_no_write: got %b want 0", wb_en_o); else n_pass++;
        drv(1'b1, 5'd9, 32'd9, 1'b1, 5'd10, 32'd10); tick();
        drv(1'b1, 5'd11, 32'd11, 1'b1, 5'd12, 32'd12); tick();
        drv(1'b1, 5'd13, 32'd13, 1'b1, 5'd0, 32'hFF); tick();
        idle();
        #1;
        n_chk++; if (stall_o !== 1'b0) $display("FAIL x0_count: stall got %b want 0", stall_o); else n_pass++;
        tick(); tick();
        n_chk++; if (wb_en_o !== 1'b1 || wb_rd_addr_o !== 5'd13 || wb_rd_data_o !== 32'd13)
            $display("FAIL x0_last: got %b %h/%h want 1 d/d", wb_en_o, wb_rd_addr_o, wb_rd_data_o); else n_pass++;
        tick();
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL x0_drained: got %b want 0", wb_en_o); else n_pass++;
    endtask

    task automatic test_reset_flush();
        drv(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2); tick();
        drv(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4); tick();
        drv(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6); tick();
        idle();
        #1;
        n_chk++; if (stall_o !== 1'b1) $display("FAIL flush_pre_stall: got %b want 1", stall_o); else n_pass++;
        rest = 1'b1; id_rs1_addr_i = 5;
        #1;
        n_chk++; if (stall_o !== 1'b0) $display("FAIL flush_stall_in_reset: got %b want 0", stall_o); else n_pass++;
        n_chk++; if (fwd_rs1_hit_o !== 1'b0) $display("FAIL flush_hit_in_reset: got %b want 0", fwd_rs1_hit_o); else n_pass++;
        tick();
        rest = 1'b0; id_rs1_addr_i = 0;
        n_chk++; if (wb_en_o !== 1'b0) $display("FAIL flush_en: got %b want 0", wb_en_o); else n_pass++;
        #1;
        n_chk++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_o); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++; if (wb_en_o !== 1'b0) $display("FAIL flush_leak_%0d: got en %b addr %h", i, wb_en_o, wb_rd_addr_o); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [32:0] f1, f2;
        rest = 1'b1; idle(); tick(); rest = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rest = ($urandom_range(0, 49) == 0);
            drv($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
            id_rs1_addr_i = 5'($urandom_range(0, 7));
            id_rs2_addr_i = 5'($urandom_range(0, 7));
            #1;
            f1 = model_fwd(id_rs1_addr_i);
            f2 = model_fwd(id_rs2_addr_i);
            n_chk++; if ({fwd_rs1_hit_o, fwd_rs1_data_o} !== f1)
                $display("FAIL rnd_fwd1 @%0d: got %b/%h want %b/%h", n, fwd_rs1_hit_o, fwd_rs1_data_o, f1[32], f1[31:0]); else n_pass++;
            n_chk++; if ({fwd_rs2_hit_o, fwd_rs2_data_o} !== f2)
                $display("FAIL rnd_fwd2 @%0d: got %b/%h want %b/%h", n, fwd_rs2_hit_o, fwd_rs2_data_o, f2[32], f2[31:0]); else n_pass++;
            n_chk++; if (stall_o !== (!rest && mq.size() > QD - 2))
                $display("FAIL rnd_stall @%0d: got %b want %b", n, stall_o, (!rest && mq.size() > QD - 2)); else n_pass++;
            tick();
            n_chk++; if (wb_en_o !== m_en) $display("FAIL rnd_en @%0d: got %b want %b", n, wb_en_o, m_en); else n_pass++;
            n_chk++; if (wb_rd_addr_o !== m_addr || wb_rd_data_o !== m_data)
                $display("FAIL rnd_wb @%0d: got %h/%h want %h/%h", n, wb_rd_addr_o, wb_rd_data_o, m_addr, m_data); else n_pass++;
            n_chk++; if (overflow_o !== m_ovf) $display("FAIL rnd_ovf @%0d: got %b want %b", n, overflow_o, m_ovf); else n_pass++;
        end
        rest = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simul();
        test_forward();
        test_overflow();
        test_x0();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
